// File: rtl/sram_lane_port.sv
// Pipelined single-port SRAM front-end with a runtime-selectable lane width.
// Narrow lane requests become row/mask/replicated-data accesses; read lanes are extracted on return.
module sram_lane_port #(
    parameter int WORD_W   = 32,
    parameter int LOG2_W   = $clog2(WORD_W),
    parameter int ROW_W    = 10,
    parameter int READ_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(LOG2_W+1)-1:0] conf,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ROW_W+LOG2_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]           req_wdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ROW_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]           mem_wmask,
    output logic [WORD_W-1:0]           mem_wdata,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic                        rsp_valid,
    output logic [WORD_W-1:0]           rsp_rdata,
    output logic                        cfg_err
);
    localparam int CONF_W = $clog2(LOG2_W + 1);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    function automatic int lane_len(input logic [CONF_W-1:0] k);
        return WORD_W >> k;
    endfunction

    function automatic logic [WORD_W-1:0] lane_ones(input logic [CONF_W-1:0] k);
        return {WORD_W{1'b1}} >> (WORD_W - lane_len(k));
    endfunction

    // Doubling the populated span each step needs only LOG2_W shifters.
    function automatic logic [WORD_W-1:0] replicate(input logic [WORD_W-1:0] d,
                                                    input logic [CONF_W-1:0] k);
        logic [WORD_W-1:0] r;
        r = d & lane_ones(k);
        for (int s = 0; s < LOG2_W; s++) begin
            if (s < int'(k)) r = r | (r << (lane_len(k) << s));
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] extract(input logic [WORD_W-1:0] d,
                                                  input logic [CONF_W-1:0] k,
                                                  input logic [LOG2_W-1:0] ln);
        return (d >> (int'(ln) * lane_len(k))) & lane_ones(k);
    endfunction

    logic [1:0]          state_q, state_d;
    logic [CONF_W-1:0]   conf_q, conf_d;
    logic [CONF_W-1:0]   conf_raw_q, conf_raw_d;
    logic                cfg_err_q, cfg_err_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ROW_W-1:0]    mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q;
    logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [READ_LAT:0]   trk_vld_q;
    logic [CONF_W-1:0]   trk_k_q    [READ_LAT+1];
    logic [LOG2_W-1:0]   trk_lane_q [READ_LAT+1];
    logic [LOG2_W-1:0]   lane;
    logic                accept;
    logic                conf_bad;

    // The raw requested value is remembered so an out-of-range conf triggers exactly one switch.
    assign req_ready = rst_n && (state_q == RUN) && (conf == conf_raw_q);
    assign accept    = req_valid && req_ready;
    assign conf_bad  = int'(conf) > LOG2_W;
    assign lane      = req_addr[LOG2_W-1:0] & LOG2_W'((1 << conf_q) - 1);

    always_comb begin
        state_d    = state_q;
        conf_d     = conf_q;
        conf_raw_d = conf_raw_q;
        cfg_err_d  = cfg_err_q;
        case (state_q)
            RUN:     if (conf != conf_raw_q) state_d = DRAIN;
            DRAIN:   if (trk_vld_q == '0) state_d = SWITCH;
            SWITCH: begin
                state_d    = RUN;
                conf_raw_d = conf;
                if (conf_bad) begin
                    conf_d    = '0;
                    cfg_err_d = 1'b1;
                end else begin
                    conf_d = conf;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mem_en_d    = accept;
        mem_we_d    = accept && req_we;
        mem_addr_d  = '0;
        mem_wmask_d = '0;
        mem_wdata_d = '0;
        if (accept) begin
            mem_addr_d = ROW_W'(req_addr >> conf_q);
            if (req_we) begin
                mem_wmask_d = lane_ones(conf_q) << (int'(lane) * lane_len(conf_q));
                mem_wdata_d = replicate(req_wdata, conf_q);
            end
        end
    end

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        if (trk_vld_q[READ_LAT])
            rsp_rdata_d = extract(mem_rdata, trk_k_q[READ_LAT], trk_lane_q[READ_LAT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            conf_q      <= '0;
            conf_raw_q  <= '0;
            cfg_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            trk_vld_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            conf_q      <= conf_d;
            conf_raw_q  <= conf_raw_d;
            cfg_err_q   <= cfg_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            trk_vld_q   <= {trk_vld_q[READ_LAT-1:0], accept && !req_we};
            rsp_valid_q <= trk_vld_q[READ_LAT];
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Mode and lane travel with each read; only the valid bits need reset.
    always_ff @(posedge clk) begin
        trk_k_q[0]    <= conf_q;
        trk_lane_q[0] <= lane;
        for (int i = 1; i <= READ_LAT; i++) begin
            trk_k_q[i]    <= trk_k_q[i-1];
            trk_lane_q[i] <= trk_lane_q[i-1];
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sram_lane_port.sv
// Directed plus randomized bench for sram_lane_port (WORD_W=32, ROW_W=10, READ_LAT=1).
// Expected values come from a lane-arithmetic reference model indexed by clock edge.
module tb_sram_lane_port;
    localparam int WORD_W   = 32;
    localparam int LOG2_W   = 5;
    localparam int ROW_W    = 10;
    localparam int READ_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  conf;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        cfg_err;

    always #5 clk = ~clk;

    sram_lane_port #(
        .WORD_W(WORD_W), .ROW_W(ROW_W), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .conf(conf),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .cfg_err(cfg_err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          rsp_seen = 0;
    logic [31:0] last_rsp = '0;
    bit          rd_acc  [0:4095];
    int          rd_k    [0:4095];
    int          rd_lane [0:4095];
    logic [31:0] rd_data [0:4095];
    int          mdl_k = 0;
    logic [2:0]  mdl_raw = '0;
    bit          mdl_err = 1'b0;
    bit          use_ovr = 1'b0;
    logic [31:0] ovr = '0;
    bit          p_en = 1'b0;
    bit          p_we = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [31:0] p_mask = '0;
    logic [31:0] p_wdata = '0;

    function automatic logic [9:0] m_row(input logic [14:0] a, input int k);
        return 10'((int'(a) / (1 << k)) % 1024);
    endfunction

    function automatic int m_lane(input logic [14:0] a, input int k);
        return int'(a) % (1 << k);
    endfunction

    function automatic logic [31:0] m_mask(input int k, input int ln);
        logic [31:0] r = '0;
        int l = 32 >> k;
        for (int i = 0; i < 32; i++) if (i / l == ln) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input int k);
        logic [31:0] r = '0;
        int l = 32 >> k;
        for (int i = 0; i < 32; i++) r[i] = d[i % l];
        return r;
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] d, input int k, input int ln);
        logic [31:0] r = '0;
        int l = 32 >> k;
        for (int i = 0; i < l; i++) r[i] = d[ln * l + i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    endtask

    // Step past the next rising edge and check everything that edge should have produced.
    task automatic advance();
        bit exp_rsp;
        @(posedge clk);
        #1;
        edge_n++;
        chk("mem_en", 32'(mem_en), 32'(p_en));
        if (p_en) begin
            chk("mem_we", 32'(mem_we), 32'(p_we));
            chk("mem_addr", 32'(mem_addr), 32'(p_addr));
            chk("mem_wmask", mem_wmask, p_mask);
            chk("mem_wdata", mem_wdata, p_wdata);
        end
        p_en = 1'b0;
        exp_rsp = (edge_n >= 2) && rd_acc[edge_n-2];
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp)
            chk("rsp_rdata", rsp_rdata,
                m_extract(rd_data[edge_n-2], rd_k[edge_n-2], rd_lane[edge_n-2]));
        if (rsp_valid) begin
            rsp_seen++;
            last_rsp = rsp_rdata;
        end
        mem_rdata = rd_acc[edge_n-1] ? rd_data[edge_n-1] : $urandom();
    endtask

    task automatic cycle(input bit v, input bit we, input logic [14:0] a,
                         input logic [31:0] d, input int exp_rdy);
        int ln;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        if (exp_rdy >= 0) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (v && req_ready) begin
            ln      = m_lane(a, mdl_k);
            p_en    = 1'b1;
            p_we    = we;
            p_addr  = m_row(a, mdl_k);
            p_mask  = we ? m_mask(mdl_k, ln) : 32'h0;
            p_wdata = we ? m_wdata(d, mdl_k) : 32'h0;
            if (!we) begin
                rd_acc[edge_n+1]  = 1'b1;
                rd_k[edge_n+1]    = mdl_k;
                rd_lane[edge_n+1] = ln;
                rd_data[edge_n+1] = use_ovr ? ovr : $urandom();
            end
        end
        advance();
        req_valid = 1'b0;
    endtask

    task automatic switch_conf(input logic [2:0] c, output int stall);
        bit done;
        stall = 0;
        conf  = c;
        if (c != mdl_raw) begin
            done = 1'b0;
            for (int i = 0; i < 16 && !done; i++) begin
                #1;
                if (req_ready) begin
                    done = 1'b1;
                end else begin
                    stall++;
                    req_valid = 1'b1;
                    req_we    = 1'b1;
                    req_addr  = 15'($urandom());
                    req_wdata = $urandom();
                    advance();
                end
            end
            req_valid = 1'b0;
            chk("switch_done", 32'(done), 1);
            chk("switch_stall_min", 32'(stall >= 2), 1);
            mdl_raw = c;
            mdl_k   = (c > 3'd5) ? 0 : int'(c);
            if (c > 3'd5) mdl_err = 1'b1;
        end
        chk("cfg_err", 32'(cfg_err), 32'(mdl_err));
    endtask

    initial begin
        int          st;
        int          n0;
        logic [2:0]  sw_c [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
        logic [31:0] sw_m [5] = '{32'hFFFFFFFF, 32'hFFFF0000, 32'hF0000000,
                                  32'hC0000000, 32'h80000000};
        logic [9:0]  sw_a [5] = '{10'h3FF, 10'h1FF, 10'h07F, 10'h03F, 10'h01F};
        logic [2:0]  rmodes [6] = '{3'd1, 3'd4, 3'd0, 3'd2, 3'd5, 3'd3};

        rst_n = 1'b1; conf = '0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        advance();
        check_all_zero("por");
        advance();
        rst_n = 1'b1;
        #1 chk("ready_after_release", 32'(req_ready), 1);

        // Write in quarter-word mode
        switch_conf(3'd2, st);
        cycle(1'b1, 1'b1, 15'h006, 32'h000000A5, 1);
        chk("t1_we", 32'(mem_we), 1);
        chk("t1_addr", 32'(mem_addr), 32'h1);
        chk("t1_mask", mem_wmask, 32'h00FF0000);
        chk("t1_wdata", mem_wdata, 32'hA5A5A5A5);

        // Read in quarter-word mode
        use_ovr = 1'b1; ovr = 32'h12345678;
        cycle(1'b1, 1'b0, 15'h005, 32'h0, 1);
        use_ovr = 1'b0;
        chk("t2_mask", mem_wmask, 32'h0);
        cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        chk("t2_rsp", last_rsp, 32'h00000056);

        // Mode sweep at the top lane address
        for (int i = 0; i < 5; i++) begin
            switch_conf(sw_c[i], st);
            cycle(1'b1, 1'b1, 15'h3FF, $urandom(), 1);
            chk("sweep_mask", mem_wmask, sw_m[i]);
            chk("sweep_addr", 32'(mem_addr), 32'(sw_a[i]));
        end

        // Mode switch while a single-bit read is in flight
        use_ovr = 1'b1; ovr = 32'h80000000;
        cycle(1'b1, 1'b0, 15'h01F, 32'h0, 1);
        use_ovr = 1'b0;
        switch_conf(3'd0, st);
        chk("drain_stall", 32'(st), 4);
        chk("drain_rsp", last_rsp, 32'h1);
        use_ovr = 1'b1; ovr = 32'hDEADBEEF;
        cycle(1'b1, 1'b0, 15'h123, 32'h0, 1);
        use_ovr = 1'b0;
        chk("full_addr", 32'(mem_addr), 32'h123);
        cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        chk("full_rsp", last_rsp, 32'hDEADBEEF);

        // Out-of-range mode
        switch_conf(3'd6, st);
        chk("bad_cfg_err", 32'(cfg_err), 1);
        cycle(1'b1, 1'b1, 15'h3FF, 32'h5A5A5A5A, 1);
        chk("bad_mask", mem_wmask, 32'hFFFFFFFF);
        chk("bad_addr", 32'(mem_addr), 32'h3FF);
        switch_conf(3'd3, st);
        chk("sticky_cfg_err", 32'(cfg_err), 1);

        // Back-to-back reads then writes
        n0 = rsp_seen;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 15'($urandom()), 32'h0, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 15'($urandom()), $urandom(), 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        chk("b2b_rsp_count", 32'(rsp_seen - n0), 4);

        // Reset with reads in flight
        cycle(1'b1, 1'b0, 15'($urandom()), 32'h0, 1);
        cycle(1'b1, 1'b0, 15'($urandom()), 32'h0, 1);
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) rd_acc[i] = 1'b0;
        #1 check_all_zero("mid_reset");
        cycle(1'b1, 1'b1, 15'h0, 32'h0, 0);
        cycle(1'b1, 1'b0, 15'h0, 32'h0, 0);
        conf = 3'd0;
        rst_n = 1'b1;
        mdl_raw = '0; mdl_k = 0; mdl_err = 1'b0;
        #1 chk("ready_after_mid_reset", 32'(req_ready), 1);
        chk("cfg_err_cleared", 32'(cfg_err), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);

        // Randomized traffic in every mode
        for (int m = 0; m < 6; m++) begin
            switch_conf(rmodes[m], st);
            for (int i = 0; i < 30; i++)
                cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      15'($urandom()), $urandom(), 1);
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 15'h0, 32'h0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
